// File: rtl/pipe_pclk_rate_ctrl.sv
// pipe_pclk_rate_ctrl: PIPE clock-rate controller running on the free-running
// DCLK. It synchronises per-lane rate requests, votes across enabled lanes,
// filters short-lived agreement and drives a glitch-free BUFGCTRL select
// sequence. A select is dropped, a quiet gap follows, the new select is raised,
// and a second quiet gap follows before completion is reported.
//
// Handshake: switch_busy is high from the edge that drops the old select until
// the edge that ends the second quiet gap. switch_done is a single-cycle pulse
// that marks every commit, with or without a clock flip. Rate requests that
// arrive while busy or done are not queued. They are re-voted from IDLE.
module pipe_pclk_rate_ctrl #(
  parameter int LANES          = 8,
  parameter int RATE_W         = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int GATE_CYCLES    = 8,
  parameter int MISMATCH_LIMIT = 64
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset_n,
  input  logic [LANES*RATE_W-1:0] pipe_rate_req,
  input  logic [LANES-1:0]        lane_en,
  output logic                    pclk_sel,
  output logic                    bufg_s0,
  output logic                    bufg_s1,
  output logic [RATE_W-1:0]       rate_cur,
  output logic                    switch_busy,
  output logic                    switch_done,
  output logic                    mismatch_err,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STABLE = 3'd1,
    GATE   = 3'd2,
    SWITCH = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int MW = $clog2(MISMATCH_LIMIT + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [MW-1:0] MM_MAX    = MW'(MISMATCH_LIMIT);

  (* ASYNC_REG = "TRUE" *) logic [LANES*RATE_W-1:0] sync_q [SYNC_STAGES];
  logic [LANES*RATE_W-1:0] sync_rate;

  state_t              state_q;
  logic [SW-1:0]       stab_cnt_q;
  logic [GW-1:0]       gate_cnt_q;
  logic [MW-1:0]       mm_cnt_q, mm_cnt_d;
  logic [RATE_W-1:0]   tgt_q;
  logic [RATE_W-1:0]   rate_cur_q;
  logic                pclk_sel_q, bufg_s0_q, bufg_s1_q;
  logic                switch_busy_q, switch_done_q, mismatch_err_q;

  logic [RATE_W-1:0]   vote_t;
  logic                any_en, agree, unan, disagree;
  logic                idle_go, stable_keep, commit;

  // Multi-flop synchroniser for the asynchronous per-lane rate requests.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pipe_rate_req;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_rate = sync_q[SYNC_STAGES-1];

  // Vote across enabled lanes. The first enabled lane sets the candidate rate.
  always_comb begin
    vote_t = '0;
    any_en = 1'b0;
    agree  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        if (!any_en) vote_t = sync_rate[i*RATE_W +: RATE_W];
        else if (sync_rate[i*RATE_W +: RATE_W] != vote_t) agree = 1'b0;
        any_en = 1'b1;
      end
    end
    unan     = any_en & agree;
    disagree = any_en & ~agree;
  end

  // Commit fires on the edge that completes STABLE_CYCLES unanimous cycles.
  always_comb begin
    idle_go     = (state_q == IDLE) && unan && (vote_t != rate_cur_q);
    stable_keep = (state_q == STABLE) && unan && (vote_t == tgt_q) &&
                  (vote_t != rate_cur_q);
    commit      = (idle_go && (STABLE_CYCLES == 1)) ||
                  (stable_keep && (stab_cnt_q == STAB_LAST));
  end

  // Saturating count of consecutive disagreeing cycles. It clears on any other cycle.
  always_comb begin
    mm_cnt_d = '0;
    if (disagree) mm_cnt_d = (mm_cnt_q == MM_MAX) ? mm_cnt_q : mm_cnt_q + 1'b1;
  end

  // Register the mismatch counter and the alarm, independent of the FSM.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      mm_cnt_q       <= '0;
      mismatch_err_q <= 1'b0;
    end else begin
      mm_cnt_q       <= mm_cnt_d;
      mismatch_err_q <= (mm_cnt_d == MM_MAX);
    end
  end

  // Switch FSM. It holds the select outputs, busy/done and the committed rate.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q       <= IDLE;
      stab_cnt_q    <= '0;
      gate_cnt_q    <= '0;
      tgt_q         <= '0;
      rate_cur_q    <= '0;
      pclk_sel_q    <= 1'b0;
      bufg_s0_q     <= 1'b1;
      bufg_s1_q     <= 1'b0;
      switch_busy_q <= 1'b0;
      switch_done_q <= 1'b0;
    end else begin
      switch_done_q <= 1'b0;
      if (commit) begin
        tgt_q      <= vote_t;
        stab_cnt_q <= '0;
        if ((|vote_t) == pclk_sel_q) begin
          // Same clock, different rate: no select activity is needed.
          rate_cur_q    <= vote_t;
          switch_done_q <= 1'b1;
          state_q       <= IDLE;
        end else begin
          // Drop whichever select is active and begin the quiet gap.
          bufg_s0_q     <= 1'b0;
          bufg_s1_q     <= 1'b0;
          switch_busy_q <= 1'b1;
          gate_cnt_q    <= '0;
          state_q       <= GATE;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (idle_go) begin
              tgt_q      <= vote_t;
              stab_cnt_q <= SW'(1);
              state_q    <= STABLE;
            end else begin
              stab_cnt_q <= '0;
            end
          end
          STABLE: begin
            if (stable_keep) begin
              stab_cnt_q <= stab_cnt_q + 1'b1;
            end else begin
              stab_cnt_q <= '0;
              state_q    <= IDLE;
            end
          end
          GATE: begin
            if (gate_cnt_q == GATE_LAST) begin
              gate_cnt_q <= '0;
              bufg_s0_q  <= ~(|tgt_q);
              bufg_s1_q  <= |tgt_q;
              pclk_sel_q <= |tgt_q;
              rate_cur_q <= tgt_q;
              state_q    <= SWITCH;
            end else begin
              gate_cnt_q <= gate_cnt_q + 1'b1;
            end
          end
          SWITCH: begin
            if (gate_cnt_q == GATE_LAST) begin
              gate_cnt_q    <= '0;
              switch_busy_q <= 1'b0;
              switch_done_q <= 1'b1;
              state_q       <= DONE;
            end else begin
              gate_cnt_q <= gate_cnt_q + 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign pclk_sel     = pclk_sel_q;
  assign bufg_s0      = bufg_s0_q;
  assign bufg_s1      = bufg_s1_q;
  assign rate_cur     = rate_cur_q;
  assign switch_busy  = switch_busy_q;
  assign switch_done  = switch_done_q;
  assign mismatch_err = mismatch_err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pipe_pclk_rate_ctrl.sv
// Directed bench for pipe_pclk_rate_ctrl using the default parameters.
// Inputs change on the falling edge. Outputs are sampled on the falling edge
// after each rising edge. "Edge e" means the e-th rising edge after an input change.
module tb_pipe_pclk_rate_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n;
  logic [15:0] pipe_rate_req;
  logic [7:0]  lane_en;
  logic        pclk_sel, bufg_s0, bufg_s1;
  logic [1:0]  rate_cur;
  logic        switch_busy, switch_done, mismatch_err;
  logic [2:0]  dbg_state;
  logic [6:0]  obs;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  pipe_pclk_rate_ctrl dut (
    .sys_clk       (sys_clk),
    .sys_reset_n   (sys_reset_n),
    .pipe_rate_req (pipe_rate_req),
    .lane_en       (lane_en),
    .pclk_sel      (pclk_sel),
    .bufg_s0       (bufg_s0),
    .bufg_s1       (bufg_s1),
    .rate_cur      (rate_cur),
    .switch_busy   (switch_busy),
    .switch_done   (switch_done),
    .mismatch_err  (mismatch_err),
    .dbg_state     (dbg_state)
  );

  assign obs = {bufg_s0, bufg_s1, pclk_sel, switch_busy, switch_done, rate_cur};

  // The two BUFGCTRL selects must never be high together.
  always @(negedge sys_clk) begin
    if (sys_reset_n === 1'b1) begin
      total++;
      if ((bufg_s0 & bufg_s1) !== 1'b0) begin
        bad++;
        $display("FAIL sel_excl: s0=%b s1=%b, required not both 1", bufg_s0, bufg_s1);
      end
    end
  end

  // Expected {s0,s1,pclk_sel,busy,done,rate} after edge e of a clock-flipping
  // switch. Commit is at edge 5, the flip at edge 13 and done at edge 21.
  function automatic logic [6:0] exp_switch(input int e, input logic [1:0] from_r,
                                            input logic from_s, input logic [1:0] to_r);
    logic to_s;
    to_s = |to_r;
    if (e < 5)        return {~from_s, from_s, from_s, 1'b0, 1'b0, from_r};
    else if (e < 13)  return {2'b00, from_s, 1'b1, 1'b0, from_r};
    else if (e < 21)  return {~to_s, to_s, to_s, 1'b1, 1'b0, to_r};
    else if (e == 21) return {~to_s, to_s, to_s, 1'b0, 1'b1, to_r};
    else              return {~to_s, to_s, to_s, 1'b0, 1'b0, to_r};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic pulse_reset();
    sys_reset_n   = 1'b0;
    pipe_rate_req = '0;
    lane_en       = 8'hFF;
    tick();
    sys_reset_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    sys_reset_n   = 1'b0;
    pipe_rate_req = '0;
    lane_en       = 8'hFF;
    repeat (3) @(negedge sys_clk);
    total++;
    if ({obs, mismatch_err} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_assert: got %b need %b", {obs, mismatch_err}, 8'b1000_0000);
    end
    total++;
    if (dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d need 0", dbg_state);
    end
    sys_reset_n = 1'b1;
    repeat (4) tick();
    total++;
    if ({obs, mismatch_err} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_idle: got %b need %b", {obs, mismatch_err}, 8'b1000_0000);
    end
  endtask

  task automatic test_gen2();
    logic [7:0] want;
    pipe_rate_req = {8{2'b01}};
    for (int e = 0; e <= 22; e++) begin
      tick();
      want = {exp_switch(e, 2'd0, 1'b0, 2'd1), 1'b0};
      total++;
      if ({obs, mismatch_err} !== want) begin
        bad++;
        $display("FAIL gen2 edge %0d: got %b need %b", e, {obs, mismatch_err}, want);
      end
    end
  endtask

  task automatic test_same_clock();
    logic [6:0] want;
    pipe_rate_req = {8{2'b10}};
    for (int e = 0; e <= 8; e++) begin
      tick();
      want = {3'b011, 1'b0, (e == 5), (e < 5) ? 2'd1 : 2'd2};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL same_clock edge %0d: got %b need %b", e, obs, want);
      end
    end
  endtask

  task automatic test_glitch();
    logic [6:0] want;
    // Three unanimous cycles at rate 0, then lane 0 breaks away.
    pipe_rate_req = '0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      want = {3'b011, 2'b00, 2'd2};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL glitch_hold edge %0d: got %b need %b", e, obs, want);
      end
      if (e == 2) pipe_rate_req[1:0] = 2'd2;
    end
    // Four unanimous cycles commit. The later break is ignored during the gap.
    pipe_rate_req[1:0] = 2'd0;
    for (int e = 0; e <= 22; e++) begin
      tick();
      want = exp_switch(e, 2'd2, 1'b1, 2'd0);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL glitch_commit edge %0d: got %b need %b", e, obs, want);
      end
      if (e == 3)  pipe_rate_req[1:0] = 2'd2;
      if (e == 13) pipe_rate_req[1:0] = 2'd0;
    end
  endtask

  task automatic test_lane_mask();
    logic [7:0] want;
    lane_en       = 8'h0F;
    pipe_rate_req = 16'h0055;
    for (int e = 0; e <= 22; e++) begin
      tick();
      want = {exp_switch(e, 2'd0, 1'b0, 2'd1), 1'b0};
      total++;
      if ({obs, mismatch_err} !== want) begin
        bad++;
        $display("FAIL mask_switch edge %0d: got %b need %b", e, {obs, mismatch_err}, want);
      end
    end
    // With no lanes enabled, disagreeing requests must cause nothing.
    lane_en       = 8'h00;
    pipe_rate_req = 16'hAA00;
    for (int e = 0; e < 30; e++) begin
      tick();
      want = {3'b011, 2'b00, 2'd1, 1'b0};
      total++;
      if ({obs, mismatch_err} !== want) begin
        bad++;
        $display("FAIL mask_none edge %0d: got %b need %b", e, {obs, mismatch_err}, want);
      end
    end
    pipe_rate_req = 16'h5555;
    repeat (4) tick();
    lane_en = 8'hFF;
    for (int e = 0; e < 6; e++) begin
      tick();
      want = {3'b011, 2'b00, 2'd1, 1'b0};
      total++;
      if ({obs, mismatch_err} !== want) begin
        bad++;
        $display("FAIL mask_restore edge %0d: got %b need %b", e, {obs, mismatch_err}, want);
      end
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] want;
    pulse_reset();
    // Lane 3 stays at 0 and the rest request 1. The first disagreeing vote is at edge 2.
    pipe_rate_req = 16'h5515;
    for (int e = 0; e < 70; e++) begin
      tick();
      want = {7'b1000000, (e >= 65)};
      total++;
      if ({obs, mismatch_err} !== want) begin
        bad++;
        $display("FAIL mismatch edge %0d: got %b need %b", e, {obs, mismatch_err}, want);
      end
    end
    pipe_rate_req = 16'h5555;
    for (int e = 0; e <= 22; e++) begin
      tick();
      want = {exp_switch(e, 2'd0, 1'b0, 2'd1), (e < 2)};
      total++;
      if ({obs, mismatch_err} !== want) begin
        bad++;
        $display("FAIL mismatch_clear edge %0d: got %b need %b", e, {obs, mismatch_err}, want);
      end
    end
  endtask

  task automatic test_reset_mid_gate();
    logic [6:0] want;
    pulse_reset();
    pipe_rate_req = 16'h5555;
    for (int e = 0; e <= 8; e++) begin
      tick();
      want = exp_switch(e, 2'd0, 1'b0, 2'd1);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL mid_gate_pre edge %0d: got %b need %b", e, obs, want);
      end
    end
    sys_reset_n = 1'b0;
    #1;
    total++;
    if ({obs, mismatch_err} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL mid_gate_async: got %b need %b", {obs, mismatch_err}, 8'b1000_0000);
    end
    total++;
    if (dbg_state !== 3'd0) begin
      bad++;
      $display("FAIL mid_gate_state: got %0d need 0", dbg_state);
    end
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      tick();
      want = exp_switch(e, 2'd0, 1'b0, 2'd1);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL mid_gate_rerun edge %0d: got %b need %b", e, obs, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gen2();
    test_same_clock();
    test_glitch();
    test_lane_mask();
    test_mismatch();
    test_reset_mid_gate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
